// File: rtl/ip4_rtl_spa_vwb.sv
// SPA write-back: per-FU result queues feeding round-robin arbitrated RFM write banks.
// Latency: push at cycle t presents wr_en at t+1; exception report one cycle after capture.
// Backpressure: in_rdy drops when an FU queue is full (registered count); wr_rdy low holds head and rr.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   in_en/in_rdy                   per-FU result valid / queue-not-full
//   in_bk/in_adr/in_tid            per-FU target bank, write address, thread id
//   in_emsk/in_exp/in_res          per-FU lane write enables, lane exception flags, lane data
//   wr_en/wr_rdy                   per-bank write request / RFM accept
//   wr_adr/wr_msk/wr_data          per-bank write payload (zero when wr_en is low)
//   exp_vld/exp_tid/exp_fu         one-cycle exception report (lowest-index excepting FU)
//   busy, ovf                      any queue non-empty, sticky overflow
module ip4_rtl_spa_vwb #(
    parameter int NUM_FU    = 3,
    parameter int NUM_SP    = 8,
    parameter int WORD_BITS = 32,
    parameter int NUM_BK    = 4,
    parameter int DEPTH     = 4,
    parameter int ADR_BITS  = 6,
    parameter int TID_BITS  = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_FU-1:0]                    in_en,
    output logic [NUM_FU-1:0]                    in_rdy,
    input  logic [NUM_FU*2-1:0]                  in_bk,
    input  logic [NUM_FU*ADR_BITS-1:0]           in_adr,
    input  logic [NUM_FU*TID_BITS-1:0]           in_tid,
    input  logic [NUM_FU*NUM_SP-1:0]             in_emsk,
    input  logic [NUM_FU*NUM_SP-1:0]             in_exp,
    input  logic [NUM_FU*NUM_SP*WORD_BITS-1:0]   in_res,
    output logic [NUM_BK-1:0]                    wr_en,
    input  logic [NUM_BK-1:0]                    wr_rdy,
    output logic [NUM_BK*ADR_BITS-1:0]           wr_adr,
    output logic [NUM_BK*NUM_SP-1:0]             wr_msk,
    output logic [NUM_BK*NUM_SP*WORD_BITS-1:0]   wr_data,
    output logic                                 exp_vld,
    output logic [TID_BITS-1:0]                  exp_tid,
    output logic [1:0]                           exp_fu,
    output logic                                 busy,
    output logic                                 ovf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int DW = NUM_SP * WORD_BITS;

    // The thread id only matters for exception reporting; the RFM write port
    // carries no thread id, so queued entries do not keep it.
    typedef struct packed {
        logic [1:0]          bk;
        logic [ADR_BITS-1:0] adr;
        logic [NUM_SP-1:0]   emsk;
        logic [DW-1:0]       res;
    } ent_t;

    ent_t            mem  [NUM_FU][DEPTH];
    ent_t            head [NUM_FU];
    logic [PW-1:0]   wptr [NUM_FU];
    logic [PW-1:0]   rptr [NUM_FU];
    logic [CW-1:0]   cnt  [NUM_FU];
    logic [RW-1:0]   rr   [NUM_BK];
    logic [RW-1:0]   gnt  [NUM_BK];
    logic [NUM_FU-1:0] is_exp, is_nrm, push, drop, pop;
    int              idx;

    // Ready depends on the registered count only: a full queue being popped
    // this cycle still refuses the new entry.
    always_comb begin
        busy = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            in_rdy[f] = (cnt[f] < CW'(DEPTH));
            busy      = busy | (cnt[f] != '0);
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            is_exp[f] = in_en[f] & (|(in_exp[f*NUM_SP +: NUM_SP] & in_emsk[f*NUM_SP +: NUM_SP]));
            is_nrm[f] = in_en[f] & ~is_exp[f] & (|in_emsk[f*NUM_SP +: NUM_SP]);
            push[f]   = is_nrm[f] & in_rdy[f];
            drop[f]   = is_nrm[f] & ~in_rdy[f];
            head[f]   = mem[f][rptr[f]];
        end
    end

    // Per-bank round robin. Scanning offsets high to low and overwriting the
    // grant leaves the candidate nearest rr[b] as the winner.
    always_comb begin
        wr_en   = '0;
        wr_adr  = '0;
        wr_msk  = '0;
        wr_data = '0;
        pop     = '0;
        idx     = 0;
        for (int b = 0; b < NUM_BK; b++) begin
            gnt[b] = '0;
            for (int k = NUM_FU - 1; k >= 0; k--) begin
                idx = int'(rr[b]) + k;
                if (idx >= NUM_FU) idx = idx - NUM_FU;
                if (cnt[idx] != '0 && head[idx].bk == 2'(b)) begin
                    wr_en[b] = 1'b1;
                    gnt[b]   = RW'(idx);
                end
            end
            if (wr_en[b]) begin
                wr_adr[b*ADR_BITS +: ADR_BITS] = head[gnt[b]].adr;
                wr_msk[b*NUM_SP +: NUM_SP]     = head[gnt[b]].emsk;
                wr_data[b*DW +: DW]            = head[gnt[b]].res;
                // Each head targets one bank, so an FU is popped at most once.
                if (wr_rdy[b]) pop[gnt[b]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < NUM_FU; f++) begin
            if (!rst && push[f]) begin
                mem[f][wptr[f]] <= '{bk:   in_bk[f*2 +: 2],
                                     adr:  in_adr[f*ADR_BITS +: ADR_BITS],
                                     emsk: in_emsk[f*NUM_SP +: NUM_SP],
                                     res:  in_res[f*DW +: DW]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FU; f++) begin
                cnt[f]  <= '0;
                wptr[f] <= '0;
                rptr[f] <= '0;
            end
            for (int b = 0; b < NUM_BK; b++) rr[b] <= '0;
            ovf     <= 1'b0;
            exp_vld <= 1'b0;
            exp_tid <= '0;
            exp_fu  <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (push[f]) wptr[f] <= wptr[f] + PW'(1);
                if (pop[f])  rptr[f] <= rptr[f] + PW'(1);
                case ({push[f], pop[f]})
                    2'b10:   cnt[f] <= cnt[f] + CW'(1);
                    2'b01:   cnt[f] <= cnt[f] - CW'(1);
                    default: ;
                endcase
            end
            for (int b = 0; b < NUM_BK; b++) begin
                if (wr_en[b] && wr_rdy[b])
                    rr[b] <= (gnt[b] == RW'(NUM_FU - 1)) ? '0 : gnt[b] + RW'(1);
            end
            if (|drop) ovf <= 1'b1;
            // Descending loop so the lowest-index excepting FU is reported.
            exp_vld <= |is_exp;
            exp_tid <= '0;
            exp_fu  <= '0;
            for (int f = NUM_FU - 1; f >= 0; f--) begin
                if (is_exp[f]) begin
                    exp_tid <= in_tid[f*TID_BITS +: TID_BITS];
                    exp_fu  <= 2'(f);
                end
            end
        end
    end

endmodule
